// File: rtl/zjh_cmp_seq.sv
// Sequential NIBBLES x 4-bit magnitude comparator, one 74HC85 slice per clock, LSB nibble first.
// Optional ZJH_CMP_SIGNED_EN: two's-complement operands (top nibble bit 3 inverted).
module zjh_cmp_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 IAGB,
    input  logic                 IASB,
    input  logic                 IAEB,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 QAGB,
    output logic                 QASB,
    output logic                 QAEB
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_q, b_q;
    logic            g, s, e;
    logic            last, accept, finish;
    logic [3:0]      na, nb;
    logic            gt, lt, eq;
    logic            g_nx, s_nx, e_nx;

    assign last = (idx == IW'(NIBBLES - 1));
    assign BUSY = (state == RUN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands shift right each step, so the current nibble is always [3:0].
    always_comb begin
        na = a_q[3:0];
        nb = b_q[3:0];
`ifdef ZJH_CMP_SIGNED_EN
        if (last) begin
            na[3] = ~a_q[3];
            nb[3] = ~b_q[3];
        end
`endif
        gt   = (na > nb);
        lt   = (na < nb);
        eq   = (na == nb);
        g_nx = gt | (eq & ~s & ~e);
        s_nx = lt | (eq & ~g & ~e);
        e_nx = eq & e;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            g    <= 1'b0;
            s    <= 1'b0;
            e    <= 1'b0;
            DONE <= 1'b0;
            QAGB <= 1'b0;
            QASB <= 1'b0;
            QAEB <= 1'b0;
        end else begin
            DONE <= finish;
            if (accept) begin
                idx <= '0;
                a_q <= A;
                b_q <= B;
                g   <= IAGB;
                s   <= IASB;
                e   <= IAEB;
            end else if (state == RUN) begin
                idx <= idx + IW'(1);
                a_q <= a_q >> 4;
                b_q <= b_q >> 4;
                g   <= g_nx;
                s   <= s_nx;
                e   <= e_nx;
                if (finish) begin
                    QAGB <= g_nx;
                    QASB <= s_nx;
                    QAEB <= e_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_zjh_cmp_seq.sv
// Testbench for zjh_cmp_seq: NIBBLES=4 and NIBBLES=1 instances checked every cycle
// against a whole-operand reference model, plus directed handshake and boundary cases.
module tb_zjh_cmp_seq;
    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] A, B;
    logic        IAGB, IASB, IAEB;
    logic        busy4, done4, qg4, qs4, qe4;
    logic        busy1, done1, qg1, qs1, qe1;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    zjh_cmp_seq #(.NIBBLES(4)) u4 (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .IAGB(IAGB), .IASB(IASB), .IAEB(IAEB),
        .BUSY(busy4), .DONE(done4), .QAGB(qg4), .QASB(qs4), .QAEB(qe4)
    );

    zjh_cmp_seq #(.NIBBLES(1)) u1 (
        .CLK(CLK), .RST(RST), .START(START), .A(A[3:0]), .B(B[3:0]),
        .IAGB(IAGB), .IASB(IASB), .IAEB(IAEB),
        .BUSY(busy1), .DONE(done1), .QAGB(qg1), .QASB(qs1), .QAEB(qe1)
    );

    // Whole-word result: a strict difference decides outright; equal words
    // leave the cascade inputs, which swap (g,s)->(~s,~g) once per slice when IAEB=0.
    function automatic logic [2:0] ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                           input logic ig, input logic is, input logic ie,
                                           input int n);
        logic [63:0]        mask;
        logic signed [63:0] sa, sb;
        int                 sh;
        logic               agt, alt;
        mask = (n == 16) ? '1 : ((64'd1 << (4 * n)) - 64'd1);
        a    = a & mask;
        b    = b & mask;
        sh   = 64 - 4 * n;
`ifdef ZJH_CMP_SIGNED_EN
        sa  = $signed(a << sh) >>> sh;
        sb  = $signed(b << sh) >>> sh;
        agt = (sa > sb);
        alt = (sa < sb);
`else
        sa  = '0;
        sb  = '0;
        agt = (a > b);
        alt = (a < b);
`endif
        if (agt)       return 3'b100;
        else if (alt)  return 3'b010;
        else if (ie)   return 3'b001;
        else if (n % 2 == 1) return {~is, ~ig, 1'b0};
        else           return {ig, is, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-level reference: a countdown per instance.
    logic       m_busy [2];
    logic       m_done [2];
    logic [2:0] m_q    [2];
    logic [2:0] m_pend [2];
    int         m_cnt  [2];

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_q[i]    = 3'b000;
                m_pend[i] = 3'b000;
                m_cnt[i]  = 0;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_q[i]    = m_pend[i];
                    end
                end else if (START) begin
                    m_pend[i] = ref_cmp({48'd0, A}, {48'd0, B}, IAGB, IASB, IAEB,
                                        (i == 0) ? 4 : 1);
                    m_busy[i] = 1'b1;
                    m_cnt[i]  = (i == 0) ? 4 : 1;
                end
            end
        end
    end

    always begin
        @(posedge CLK);
        #3;
        chk("busy4", {3'b0, busy4}, {3'b0, m_busy[0]});
        chk("done4", {3'b0, done4}, {3'b0, m_done[0]});
        chk("q4", {1'b0, qg4, qs4, qe4}, {1'b0, m_q[0]});
        chk("busy1", {3'b0, busy1}, {3'b0, m_busy[1]});
        chk("done1", {3'b0, done1}, {3'b0, m_done[1]});
        chk("q1", {1'b0, qg1, qs1, qe1}, {1'b0, m_q[1]});
    end

    // Caller is at a negedge; returns at the negedge of the DONE cycle.
    task automatic run(input int n, input logic [15:0] a, input logic [15:0] b,
                       input logic ig, input logic is, input logic ie,
                       input logic [2:0] exp, input string nm);
        A = a; B = b; IAGB = ig; IASB = is; IAEB = ie; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({nm, "_busy"}, {3'b0, (n == 4) ? busy4 : busy1}, 4'd1);
            @(negedge CLK);
        end
        chk({nm, "_done"}, {3'b0, (n == 4) ? done4 : done1}, 4'd1);
        chk({nm, "_q"}, (n == 4) ? {1'b0, qg4, qs4, qe4} : {1'b0, qg1, qs1, qe1},
            {1'b0, exp});
    endtask

    int dcount;
    int mode;

    initial begin
        RST = 1'b1; START = 1'b0; A = '0; B = '0;
        IAGB = 1'b0; IASB = 1'b0; IAEB = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_q4", {busy4, qg4, qs4, qe4}, 4'b0000);
        chk("rst_done4", {3'b0, done4}, 4'd0);
        RST = 1'b0;
        @(negedge CLK);

        chk("pin_eq", {1'b0, ref_cmp(64'h1234, 64'h1234, 0, 0, 1, 4)}, 4'b0001);
        chk("pin_low", {1'b0, ref_cmp(64'h1235, 64'h1234, 0, 0, 1, 4)}, 4'b0100);
        chk("pin_c100", {1'b0, ref_cmp(64'hABCD, 64'hABCD, 1, 0, 0, 4)}, 4'b0100);
        chk("pin_c000", {1'b0, ref_cmp(64'hABCD, 64'hABCD, 0, 0, 0, 4)}, 4'b0000);
        chk("pin_c111", {1'b0, ref_cmp(64'hABCD, 64'hABCD, 1, 1, 1, 4)}, 4'b0001);
        chk("pin_n1_c000", {1'b0, ref_cmp(64'h5, 64'h5, 0, 0, 0, 1)}, 4'b0110);

        run(4, 16'h1234, 16'h1234, 0, 0, 1, 3'b001, "eq");
        run(4, 16'h1235, 16'h1234, 0, 0, 1, 3'b100, "low");
`ifdef ZJH_CMP_SIGNED_EN
        run(4, 16'h8000, 16'h7FFF, 0, 0, 1, 3'b010, "sgn");
        run(4, 16'hFFFF, 16'h0000, 0, 0, 1, 3'b010, "ff00");
        run(4, 16'h0000, 16'hFFFF, 0, 0, 1, 3'b100, "00ff");
`else
        run(4, 16'h8000, 16'h7FFF, 0, 0, 1, 3'b100, "sgn");
        run(4, 16'hFFFF, 16'h0000, 0, 0, 1, 3'b100, "ff00");
        run(4, 16'h0000, 16'hFFFF, 0, 0, 1, 3'b010, "00ff");
`endif
        run(4, 16'hABCD, 16'hABCD, 1, 0, 0, 3'b100, "c100");
        run(4, 16'hABCD, 16'hABCD, 0, 0, 0, 3'b000, "c000");
        run(4, 16'hABCD, 16'hABCD, 1, 1, 1, 3'b001, "c111");
        repeat (6) @(negedge CLK);

`ifdef ZJH_CMP_SIGNED_EN
        run(1, 16'h000F, 16'h0000, 0, 0, 1, 3'b010, "n1_f0");
`else
        run(1, 16'h000F, 16'h0000, 0, 0, 1, 3'b100, "n1_f0");
`endif
        run(1, 16'h0007, 16'h0007, 0, 0, 0, 3'b110, "n1_c000");
        repeat (6) @(negedge CLK);

        // START held: one comparison per 5 cycles
        A = 16'h1111; B = 16'h2222; START = 1'b1;
        dcount = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            if (i == 10) START = 1'b0;
            if (done4) dcount++;
        end
        chk("hold_dones", dcount[3:0], 4'd2);
        repeat (6) @(negedge CLK);

        // START at idx=2 is ignored
        A = 16'h1235; B = 16'h1234; IAGB = 0; IASB = 0; IAEB = 1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        A = 16'h0000; B = 16'hFFFF; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        chk("ign_done", {3'b0, done4}, 4'd1);
        chk("ign_q", {1'b0, qg4, qs4, qe4}, 4'b0100);
        dcount = 0;
        repeat (6) begin
            @(negedge CLK);
            if (done4) dcount++;
        end
        chk("ign_nodone", dcount[3:0], 4'd0);

        // Reset at idx=2
        A = 16'h4321; B = 16'h1234; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid_rst", {busy4, qg4, qs4, qe4}, 4'b0000);
        chk("mid_rst_done", {3'b0, done4}, 4'd0);
        @(negedge CLK);
        RST = 1'b0;
        dcount = 0;
        repeat (8) begin
            @(negedge CLK);
            if (done4) dcount++;
        end
        chk("rst_nodone", dcount[3:0], 4'd0);
        run(4, 16'h4321, 16'h1234, 0, 0, 1, 3'b100, "post_rst");

        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            mode  = int'($urandom_range(0, 3));
            A     = 16'($urandom);
            B     = (mode == 0) ? 16'($urandom) :
                    (mode == 1) ? A : (A ^ (16'h1 << (4 * $urandom_range(0, 3))));
            IAGB  = 1'($urandom);
            IASB  = 1'($urandom);
            IAEB  = 1'($urandom);
            START = ($urandom_range(0, 2) != 0);
            RST   = ($urandom_range(0, 79) == 0);
        end
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        repeat (8) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
